// File: rtl/irq_prio_ctrl_pkg.sv
// rtl/irq_prio_ctrl_pkg.sv - shared constants, state type and helpers for irq_prio_ctrl
package irq_prio_pkg;
  localparam int N_SRC           = 4;
  localparam int ID_W            = 2;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, GAP} state_t;

  function automatic logic [N_SRC-1:0] id_onehot(input logic [ID_W-1:0] id);
    return N_SRC'(1) << id;
  endfunction
endpackage

// File: rtl/irq_prio_ctrl_if.sv
// rtl/irq_prio_ctrl_if.sv - request/mask/ack handshake and status bundle for irq_prio_ctrl
interface irq_prio_ctrl_if;
  import irq_prio_pkg::*;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] mask;
  logic             en;
  logic             ack;
  logic             irq;
  logic [ID_W-1:0]  irq_id;
  logic             gs;
  logic [N_SRC-1:0] pending;
  logic             timeout;

  modport master (output req, mask, en, ack,
                  input  irq, irq_id, gs, pending, timeout);
  modport slave  (input  req, mask, en, ack,
                  output irq, irq_id, gs, pending, timeout);
endinterface

// File: rtl/irq_prio_ctrl_pick.sv
// rtl/irq_prio_ctrl_pick.sv - combinational highest-index picker (bit 3 wins)
module irq_prio_pick
  import irq_prio_pkg::*;
(
  input  logic [N_SRC-1:0] cand,
  output logic [ID_W-1:0]  sel,
  output logic             any
);
  always_comb begin
    sel = '0;
    any = |cand;
    // Ascending scan so the last (highest) set index is the one kept.
    for (int i = 0; i < N_SRC; i++) begin
      if (cand[i]) sel = ID_W'(i);
    end
  end
endmodule

// File: rtl/irq_prio_ctrl.sv
// rtl/irq_prio_ctrl.sv - edge-captured, masked, prioritised irq presenter with ack handshake; optional IRQ_TIMEOUT_EN
module irq_prio_ctrl
  import irq_prio_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
(
  input  logic              clk,
  input  logic              rst,
  irq_prio_ctrl_if.slave    bus
);
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_timeout_range
    $error("irq_prio_ctrl: TIMEOUT_CYC must be within 2..255");
  end

  logic [N_SRC-1:0] req_d;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] set_v;
  logic [N_SRC-1:0] clr_v;
  logic [ID_W-1:0]  sel;
  logic             any;
  state_t           state, state_nx;
  logic             irq_q, irq_nx;
  logic [ID_W-1:0]  id_q, id_nx;
  logic             gs_q;
`ifdef IRQ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q, cnt_nx;
  logic       to_q, to_nx;
`endif

  assign set_v = bus.req & ~req_d;
  assign cand  = pending_q & ~bus.mask;

  irq_prio_pick u_pick (
    .cand (cand),
    .sel  (sel),
    .any  (any)
  );

  always_comb begin
    state_nx = state;
    irq_nx   = irq_q;
    id_nx    = id_q;
    clr_v    = '0;
`ifdef IRQ_TIMEOUT_EN
    cnt_nx   = cnt_q;
    to_nx    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.en && any) begin
          id_nx    = sel;
          irq_nx   = 1'b1;
          state_nx = WAIT_ACK;
`ifdef IRQ_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      WAIT_ACK: begin
        // Presented id is frozen here: no preemption, no retraction on en/mask.
        if (bus.ack) begin
          clr_v    = id_onehot(id_q);
          irq_nx   = 1'b0;
          state_nx = GAP;
        end
`ifdef IRQ_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          irq_nx   = 1'b0;
          to_nx    = 1'b1;
          state_nx = GAP;
        end else begin
          cnt_nx   = cnt_q + 8'd1;
        end
`endif
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq_q     <= 1'b0;
      id_q      <= '0;
      gs_q      <= 1'b0;
      pending_q <= '0;
      req_d     <= bus.req;
`ifdef IRQ_TIMEOUT_EN
      cnt_q     <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      irq_q     <= irq_nx;
      id_q      <= id_nx;
      gs_q      <= any;
      // Set term is ORed last so a fresh edge survives a same-cycle clear.
      pending_q <= set_v | (pending_q & ~clr_v);
      req_d     <= bus.req;
`ifdef IRQ_TIMEOUT_EN
      cnt_q     <= cnt_nx;
      to_q      <= to_nx;
`endif
    end
  end

  assign bus.irq     = irq_q;
  assign bus.irq_id  = id_q;
  assign bus.gs      = gs_q;
  assign bus.pending = pending_q;
`ifdef IRQ_TIMEOUT_EN
  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_irq_prio_ctrl.sv
// tb/tb_irq_prio_ctrl.sv - directed plus randomized check of irq_prio_ctrl against a behavioural model
module tb_irq_prio_ctrl;
  import irq_prio_pkg::*;

  localparam int TB_TO = 4;
`ifdef IRQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  irq_prio_ctrl_if bus ();

  irq_prio_ctrl #(.TIMEOUT_CYC(TB_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int highest(input bit [3:0] v);
    int h = -1;
    for (int i = 0; i < 4; i++) if (v[i]) h = i;
    return h;
  endfunction

  // Model: which source is being presented (-1 none), whether a gap cycle is owed, and the pending set.
  bit [3:0] m_pend, m_req_prev, m_set, m_cand, m_clr;
  int       m_cur = -1;
  int       m_id  = 0;
  int       m_cnt = 0;
  bit       m_gap, m_gs, m_to;
  bit       started = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_pend = '0; m_cur = -1; m_id = 0; m_gap = 0; m_gs = 0; m_to = 0; m_cnt = 0;
      m_req_prev = bus.req;
      started = 1'b1;
    end else if (started) begin
      m_set  = bus.req & ~m_req_prev;
      m_cand = m_pend & ~bus.mask;
      m_clr  = '0;
      m_gs   = (m_cand != 0);
      m_to   = 1'b0;
      if (m_cur >= 0) begin
        if (bus.ack) begin
          m_clr[m_cur] = 1'b1;
          m_cur = -1;
          m_gap = 1'b1;
        end else if (TO_EN && m_cnt == TB_TO - 1) begin
          m_cur = -1;
          m_gap = 1'b1;
          m_to  = 1'b1;
        end else begin
          m_cnt++;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (bus.en && m_cand != 0) begin
        m_cur = highest(m_cand);
        m_id  = m_cur;
        m_cnt = 0;
      end
      m_pend = m_set | (m_pend & ~m_clr);
      m_req_prev = bus.req;
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("model_irq", bus.irq, 32'(m_cur >= 0));
      check("model_pending", bus.pending, 32'(m_pend));
      check("model_gs", bus.gs, 32'(m_gs));
      check("model_timeout", bus.timeout, 32'(m_to));
      if (m_cur >= 0) check("model_irq_id", bus.irq_id, 32'(m_id));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_ids[4] = '{3, 2, 1, 0};
    logic [3:0] r;

    rst = 1'b1; bus.req = 4'b0101; bus.mask = '0; bus.en = 1'b1; bus.ack = 1'b0;
    tick(); tick();
    check("reset_irq_id", bus.irq_id, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rel_pending", bus.pending, 0);
      check("rel_irq", bus.irq, 0);
    end
    bus.req = 4'b0000; tick();

    // Single source, latency and clear.
    bus.req = 4'b0010; tick();
    check("s1_pending", bus.pending, 4'b0010);
    check("s1_irq_early", bus.irq, 0);
    bus.req = 4'b0000; tick();
    check("s1_irq", bus.irq, 1);
    check("s1_id", bus.irq_id, 1);
    bus.ack = 1'b1; tick();
    check("s1_irq_off", bus.irq, 0);
    check("s1_pend_clr", bus.pending, 0);
    bus.ack = 1'b0; tick();

    // All four at once: served 3,2,1,0.
    bus.req = 4'b1111; tick();
    check("b2b_pending", bus.pending, 4'b1111);
    bus.req = 4'b0000; tick();
    check("b2b_gs", bus.gs, 1);
    for (int k = 0; k < 4; k++) begin
      check("b2b_irq", bus.irq, 1);
      check("b2b_id", bus.irq_id, 32'(exp_ids[k]));
      bus.ack = 1'b1; tick();
      bus.ack = 1'b0;
      check("b2b_drop", bus.irq, 0);
      tick();
      check("b2b_gap", bus.irq, 0);
      if (k == 3) check("b2b_gs_fall", bus.gs, 0);
      tick();
    end
    check("b2b_idle", bus.irq, 0);

    // No preemption by a higher source.
    bus.req = 4'b0001; tick();
    bus.req = 4'b0000; tick();
    check("np_id0", bus.irq_id, 0);
    bus.req = 4'b1000; tick();
    bus.req = 4'b0000; tick();
    check("np_hold_irq", bus.irq, 1);
    check("np_hold_id", bus.irq_id, 0);
    bus.ack = 1'b1; tick();
    bus.ack = 1'b0; tick(); tick();
    check("np_next_irq", bus.irq, 1);
    check("np_next_id", bus.irq_id, 3);
    bus.ack = 1'b1; tick();
    bus.ack = 1'b0; tick(); tick();

    // Masked source waits until unmasked.
    bus.mask = 4'b1000; bus.req = 4'b1001; tick();
    bus.req = 4'b0000; tick();
    check("mk_id", bus.irq_id, 0);
    bus.ack = 1'b1; tick();
    bus.ack = 1'b0; tick(); tick();
    check("mk_irq_off", bus.irq, 0);
    check("mk_pending", bus.pending, 4'b1000);
    check("mk_gs", bus.gs, 0);
    bus.mask = 4'b0000; tick();
    check("mk_irq3", bus.irq, 1);
    check("mk_id3", bus.irq_id, 3);
    bus.ack = 1'b1; tick();
    bus.ack = 1'b0; tick(); tick();

    // Re-trigger coinciding with ack keeps the bit pending.
    bus.req = 4'b0100; tick();
    bus.req = 4'b0000; tick();
    check("rt_id", bus.irq_id, 2);
    bus.req = 4'b0100; bus.ack = 1'b1; tick();
    check("rt_drop", bus.irq, 0);
    check("rt_pending", bus.pending, 4'b0100);
    bus.req = 4'b0000; bus.ack = 1'b0; tick(); tick();
    check("rt_again", bus.irq, 1);
    check("rt_again_id", bus.irq_id, 2);
    bus.ack = 1'b1; tick();
    bus.ack = 1'b0; tick(); tick();

    // en gates start only.
    bus.en = 1'b0; bus.req = 4'b0010; tick();
    bus.req = 4'b0000; tick(); tick();
    check("en_block", bus.irq, 0);
    check("en_pending", bus.pending, 4'b0010);
    bus.en = 1'b1; tick();
    check("en_start", bus.irq, 1);
    bus.en = 1'b0; tick();
    check("en_no_retract", bus.irq, 1);
    bus.en = 1'b1; bus.ack = 1'b1; tick();
    bus.ack = 1'b0; tick(); tick();

    // Reset mid-handshake.
    bus.req = 4'b0001; tick();
    bus.req = 4'b0000; tick();
    check("rm_irq", bus.irq, 1);
    rst = 1'b1; tick();
    check("rm_irq_off", bus.irq, 0);
    check("rm_pending", bus.pending, 0);
    rst = 1'b0; tick();

`ifdef IRQ_TIMEOUT_EN
    bus.req = 4'b0100; tick();
    bus.req = 4'b0000; tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait", bus.irq, 1);
    end
    tick();
    check("to_drop", bus.irq, 0);
    check("to_pulse", bus.timeout, 1);
    check("to_keep", bus.pending, 4'b0100);
    tick();
    check("to_pulse_end", bus.timeout, 0);
    tick();
    check("to_repr", bus.irq, 1);
    check("to_repr_id", bus.irq_id, 2);
    bus.ack = 1'b1; tick();
    bus.ack = 1'b0; tick(); tick();
`endif

    for (int c = 0; c < 3000; c++) begin
      r = '0;
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) r[i] = 1'b1;
      bus.req = bus.req ^ r;
      bus.ack = ($urandom_range(0, 2) == 0);
      bus.en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) bus.mask = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
